// File: rtl/freq_counter_core.sv
// rtl/freq_counter_core.sv - gated rising-edge counter for one selectable test signal
//
// Purpose:
//   Picks one bit of the in_signal bundle, passes it through a two-flop
//   synchroniser, and counts its rising edges over a window of gate_cycles
//   system-clock cycles. The result stays on the outputs until the next
//   accepted start.
//
// Ports:
//   clock        system clock; all logic runs on the rising edge
//   reset        asynchronous, active-high reset
//   in_signal    asynchronous signals under measurement
//   start        one-cycle request; captures sel and gate_cycles
//   sel          index of the in_signal bit to measure
//   gate_cycles  window length in clock cycles
//   busy         measurement in progress (ARM or GATE)
//   done         result valid; held until the next accepted start
//   count        rising edges seen in the window, saturating
//   overflow     an edge arrived while count was already saturated
//   invalid_sel  captured sel was outside the in_signal bus
module freq_counter_core #(
    parameter int NUM_INPUTS  = 24,
    parameter int SEL_WIDTH   = 5,
    parameter int GATE_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_INPUTS-1:0]  in_signal,
    input  logic                   start,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic [GATE_WIDTH-1:0]  gate_cycles,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow,
    output logic                   invalid_sel
);

    localparam int SEL_SPAN = 2 ** SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] NUM_IN = (SEL_WIDTH + 1)'(NUM_INPUTS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_INPUTS-1:0] sync_meta;
    logic [NUM_INPUTS-1:0] sync_q;
    logic [SEL_SPAN-1:0]   sync_wide;
    logic                  prev_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [GATE_WIDTH-1:0] gate_q;
    logic [GATE_WIDTH-1:0] remaining;

    logic accept;
    logic sel_bad;
    logic gate_zero;
    logic cur_bit;
    logic edge_pulse;

    // start is only honoured when no measurement is running.
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign sel_bad   = ({1'b0, sel} >= NUM_IN);
    assign gate_zero = (gate_cycles == '0);

    // Zero-extend so every sel value is a legal index; an out-of-range sel
    // never reaches ARM/GATE anyway.
    assign sync_wide  = SEL_SPAN'(sync_q);
    assign cur_bit    = sync_wide[sel_q];
    assign edge_pulse = cur_bit & ~prev_q;

    // Two-flop synchroniser on every input bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= in_signal;
            sync_q    <= sync_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (sel_bad || gate_zero) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ARM;
                    end
                end
            end
            S_ARM: begin
                state_next = S_GATE;
            end
            S_GATE: begin
                // remaining was loaded with N in ARM, so this exits after N GATE cycles.
                if (remaining == GATE_WIDTH'(1)) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_ARM, S_GATE: busy = 1'b1;
            S_DONE:        done = 1'b1;
            default:       busy = 1'b0;
        endcase
    end

    // Measurement datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q      <= 1'b0;
            sel_q       <= '0;
            gate_q      <= '0;
            remaining   <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            invalid_sel <= 1'b0;
        end else begin
            if (accept) begin
                sel_q       <= sel;
                gate_q      <= gate_cycles;
                count       <= '0;
                overflow    <= 1'b0;
                invalid_sel <= sel_bad;
            end

            if (state == S_ARM) begin
                // Seed prev_q with the current level so a signal that is
                // already high at window start does not register as an edge.
                prev_q    <= cur_bit;
                remaining <= gate_q;
            end

            if (state == S_GATE) begin
                prev_q    <= cur_bit;
                remaining <= remaining - GATE_WIDTH'(1);
                if (edge_pulse) begin
                    if (&count) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_counter_core.sv
// tb/tb_freq_counter_core.sv - self-checking bench for freq_counter_core
module tb_freq_counter_core;

    logic        clock;
    logic        reset;
    logic        sig0, sig1, sig2;
    logic [23:0] in_signal;
    logic        start1, start2;
    logic [4:0]  sel;
    logic [31:0] gate_cycles;

    logic        busy1, done1, ovf1, inv1;
    logic [31:0] count1;
    logic        busy2, done2, ovf2, inv2;
    logic [3:0]  count2;

    int which;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    lo;
        int    hi;
        bit    ovf;
        bit    inv;
        int    lat;
    } exp_t;

    exp_t sb[$];

    assign in_signal = {21'b0, sig2, sig1, sig0};

    freq_counter_core dut1 (
        .clock(clock), .reset(reset), .in_signal(in_signal), .start(start1),
        .sel(sel), .gate_cycles(gate_cycles), .busy(busy1), .done(done1),
        .count(count1), .overflow(ovf1), .invalid_sel(inv1)
    );

    freq_counter_core #(.COUNT_WIDTH(4)) dut2 (
        .clock(clock), .reset(reset), .in_signal(in_signal), .start(start2),
        .sel(sel), .gate_cycles(gate_cycles), .busy(busy2), .done(done2),
        .count(count2), .overflow(ovf2), .invalid_sel(inv2)
    );

    logic        obs_busy, obs_done, obs_ovf, obs_inv;
    logic [31:0] obs_count;
    assign obs_busy  = (which == 2) ? busy2 : busy1;
    assign obs_done  = (which == 2) ? done2 : done1;
    assign obs_ovf   = (which == 2) ? ovf2  : ovf1;
    assign obs_inv   = (which == 2) ? inv2  : inv1;
    assign obs_count = (which == 2) ? {28'b0, count2} : count1;

    // 100 MHz system clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // sig1: 10 MHz square wave; sig2: 25 MHz (toggle every 2 cycles).
    // Offsets keep input transitions away from clock edges.
    initial begin
        sig1 = 1'b0;
        #3;
        forever begin
            #50 sig1 = ~sig1;
        end
    end

    initial begin
        sig2 = 1'b0;
        #7;
        forever begin
            #20 sig2 = ~sig2;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input longint obs, input longint lo, input longint hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic start_pulse(input int w);
        if (w == 2) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Launch one measurement, record its expected result, then wait for done
    // and score it. poke_at >= 0 re-pulses start that many cycles into the run.
    task automatic measure(input int w, input logic [4:0] s, input int n,
                           input int lo, input int hi, input bit ovf, input bit inv,
                           input int poke_at, input string tag);
        exp_t e;
        exp_t got;
        int   k;
        e.tag = tag;
        e.lo  = lo;
        e.hi  = hi;
        e.ovf = ovf;
        e.inv = inv;
        e.lat = (inv || n == 0) ? 0 : n + 1;
        sb.push_back(e);

        which       = w;
        sel         = s;
        gate_cycles = n;
        start_pulse(w);
        // Return the shared inputs to values a second start would reject.
        sel         = 5'd2;
        gate_cycles = 32'd1000;

        got = sb.pop_front();
        chk({got.tag, " busy_after_start"}, obs_busy, (got.lat > 0) ? 1 : 0);

        k = 0;
        while (!obs_done && k < n + 20) begin
            if (k == poke_at) start_pulse(w);
            else begin
                @(posedge clock);
                #1;
            end
            k++;
        end
        chk({got.tag, " done"}, obs_done, 1);
        chk({got.tag, " latency"}, k, got.lat);
        chk({got.tag, " busy_at_done"}, obs_busy, 0);
        chk_range({got.tag, " count"}, obs_count, got.lo, got.hi);
        chk({got.tag, " overflow"}, obs_ovf, got.ovf);
        chk({got.tag, " invalid_sel"}, obs_inv, got.inv);
    endtask

    initial begin
        which       = 1;
        reset       = 1'b1;
        start1      = 1'b0;
        start2      = 1'b0;
        sel         = '0;
        gate_cycles = '0;
        sig0        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", busy1, 0);
        chk("reset done", done1, 0);
        chk("reset count", count1, 0);
        chk("reset overflow", ovf1, 0);
        chk("reset invalid_sel", inv1, 0);
        chk("reset dut2 count", count2, 0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // 10 MHz over 1000 cycles at 100 MHz -> 100 edges, +/-1 for phase.
        measure(1, 5'd1, 1000, 99, 101, 1'b0, 1'b0, -1, "t1_10mhz");
        // sel 0 held high for a long time: ARM must not see a false edge.
        measure(1, 5'd0, 50, 0, 0, 1'b0, 1'b0, -1, "t2_static_high");
        // Zero-length window.
        measure(1, 5'd1, 0, 0, 0, 1'b0, 1'b0, -1, "t3_gate0");
        // Out-of-range sel, then a valid start must clear invalid_sel.
        measure(1, 5'd30, 100, 0, 0, 1'b0, 1'b1, -1, "t4_bad_sel");
        measure(1, 5'd0, 5, 0, 0, 1'b0, 1'b0, -1, "t4_clear");
        // 25 MHz over 80 cycles -> 20 edges; 4-bit counter saturates.
        measure(1, 5'd2, 80, 19, 21, 1'b0, 1'b0, -1, "t5_wide");
        measure(2, 5'd2, 80, 15, 15, 1'b1, 1'b0, -1, "t5_sat");
        // Second start 20 cycles in is ignored; window stays 100 cycles.
        measure(1, 5'd1, 100, 9, 11, 1'b0, 1'b0, 20, "t6_ignored_start");

        // Reset mid-window clears outputs without waiting for a clock edge.
        which       = 1;
        sel         = 5'd1;
        gate_cycles = 32'd200;
        start_pulse(1);
        repeat (50) @(posedge clock);
        #1;
        chk("t6 busy_mid_window", busy1, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6 reset busy", busy1, 0);
        chk("t6 reset done", done1, 0);
        chk("t6 reset count", count1, 0);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("t6 idle after reset", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
